// File: rtl/ysyx_23060075_muldiv_iter_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_muldiv_iter_if
// Request/response bundle for the iterative multiply/divide unit.
//   in_valid/in_ready : request handshake (op, a, b travel with it)
//   out_valid/out_ready : response handshake (result, div_by_zero travel with it)
// master = requester/consumer side, slave = the arithmetic unit.
// ---------------------------------------------------------------------------
interface ysyx_23060075_muldiv_iter_if #(
   parameter int data_len = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [2:0]          op;
   logic [data_len-1:0] a;
   logic [data_len-1:0] b;
   logic                out_valid;
   logic                out_ready;
   logic [data_len-1:0] result;
   logic                div_by_zero;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, div_by_zero
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, div_by_zero
   );
endinterface

// File: rtl/ysyx_23060075_muldiv_iter.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_muldiv_iter
// Iterative RISC-V M-extension unit: one shift-add (multiply) or one restoring
// shift-subtract (divide) step per cycle, data_len steps per operation.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   flush : drop any in-flight operation, return to IDLE
//   io    : slave side of ysyx_23060075_muldiv_iter_if (request/response)
// Build option: define YSYX_23060075_MULDIV_DIV_EN to include the divider.
// Without it, ops 4-7 complete one cycle after accept with result 0.
// ---------------------------------------------------------------------------
module ysyx_23060075_muldiv_iter #(
   parameter int data_len = 32
) (
   input logic                         clk,
   input logic                         rst,
   input logic                         flush,
   ysyx_23060075_muldiv_iter_if.slave  io
);
   localparam int CW = $clog2(data_len) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state, w_state_nx;
   logic [2:0]          r_op;
   logic [data_len-1:0] r_hi;      // product high half / partial remainder
   logic [data_len-1:0] r_lo;      // multiplier / dividend shifting into quotient
   logic [data_len-1:0] r_mcand;   // multiplicand or divisor magnitude
   logic                r_neg_q;   // product / quotient needs negation
   logic [CW-1:0]       r_cnt;
   logic [data_len-1:0] r_result;
   logic                r_dbz;

   // ---------------- accept-side decode ----------------
   logic                w_accept, w_bypass, w_byp_dbz, w_sa, w_sb;
   logic [data_len-1:0] w_amag, w_bmag, w_byp_res;

   assign w_accept = (r_state == S_IDLE) && io.in_valid && !flush;
   assign w_sa = (io.op == 3'd1 || io.op == 3'd2 || io.op == 3'd4 || io.op == 3'd6)
                 && io.a[data_len-1];
   assign w_sb = (io.op == 3'd1 || io.op == 3'd4 || io.op == 3'd6) && io.b[data_len-1];
   // -MIN wraps to MIN, which is the correct unsigned magnitude
   assign w_amag = w_sa ? -io.a : io.a;
   assign w_bmag = w_sb ? -io.b : io.b;

`ifdef YSYX_23060075_MULDIV_DIV_EN
   logic r_neg_r;                  // remainder takes the dividend's sign
   logic w_b_zero, w_ovf;
   assign w_b_zero  = (io.b == '0);
   assign w_ovf     = (io.op == 3'd4 || io.op == 3'd6)
                      && (io.a == {1'b1, {(data_len-1){1'b0}}}) && (&io.b);
   assign w_bypass  = io.op[2] && (w_b_zero || w_ovf);
   assign w_byp_dbz = io.op[2] && w_b_zero;
   // op[1] distinguishes REM/REMU from DIV/DIVU
   assign w_byp_res = w_b_zero ? (io.op[1] ? io.a : '1)
                               : (io.op[1] ? '0 : io.a);
`else
   assign w_bypass  = io.op[2];
   assign w_byp_dbz = 1'b0;
   assign w_byp_res = '0;
`endif

   // ---------------- shared step adder ----------------
   logic [data_len:0]   w_opa, w_opb;
   logic [data_len-1:0] w_hi_nx, w_lo_nx;

`ifdef YSYX_23060075_MULDIV_DIV_EN
   // Carry out (bit data_len+1) of shift - divisor signals "no borrow".
   logic [data_len+1:0] w_sum;
   logic [data_len:0]   w_shift;
   logic                w_cin;
   assign w_shift = {r_hi, r_lo[data_len-1]};
   assign w_sum   = {1'b0, w_opa} + {1'b0, w_opb} + {{(data_len+1){1'b0}}, w_cin};
`else
   logic [data_len:0]   w_sum;
   assign w_sum = w_opa + w_opb;
`endif

   always_comb begin
      w_opa = {1'b0, r_hi};
      w_opb = r_lo[0] ? {1'b0, r_mcand} : '0;
`ifdef YSYX_23060075_MULDIV_DIV_EN
      w_cin = 1'b0;
      if (r_op[2]) begin
         w_opa = w_shift;
         w_opb = ~{1'b0, r_mcand};
         w_cin = 1'b1;
      end
`endif
   end

   always_comb begin
      // multiply: add then shift the {hi,lo} pair right by one
      w_hi_nx = w_sum[data_len:1];
      w_lo_nx = {w_sum[0], r_lo[data_len-1:1]};
`ifdef YSYX_23060075_MULDIV_DIV_EN
      if (r_op[2]) begin
         w_hi_nx = w_sum[data_len+1] ? w_sum[data_len-1:0] : w_shift[data_len-1:0];
         w_lo_nx = {r_lo[data_len-2:0], w_sum[data_len+1]};
      end
`endif
   end

   // ---------------- final selection with sign fix ----------------
   logic [2*data_len-1:0] w_prod, w_prod_s;
   logic [data_len-1:0]   w_final;

   assign w_prod   = {w_hi_nx, w_lo_nx};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;

   always_comb begin
      w_final = (r_op == 3'd0) ? w_prod_s[data_len-1:0] : w_prod_s[2*data_len-1:data_len];
`ifdef YSYX_23060075_MULDIV_DIV_EN
      if (r_op[2])
         w_final = r_op[1] ? (r_neg_r ? -w_hi_nx : w_hi_nx)
                           : (r_neg_q ? -w_lo_nx : w_lo_nx);
`endif
   end

   logic w_last;
   assign w_last = (r_cnt == CW'(data_len - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nx = w_bypass ? S_DONE : S_BUSY;
         S_BUSY: if (w_last) w_state_nx = S_DONE;
         S_DONE: if (io.out_ready) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
      if (flush) w_state_nx = S_IDLE;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_mcand  <= '0;
         r_neg_q  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_dbz    <= 1'b0;
`ifdef YSYX_23060075_MULDIV_DIV_EN
         r_neg_r  <= 1'b0;
`endif
      end else if (flush) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_op    <= io.op;
               r_cnt   <= '0;
               r_hi    <= '0;
               r_lo    <= io.op[2] ? w_amag : w_bmag;
               r_mcand <= io.op[2] ? w_bmag : w_amag;
               r_neg_q <= w_sa ^ w_sb;
`ifdef YSYX_23060075_MULDIV_DIV_EN
               r_neg_r <= w_sa;
`endif
               r_dbz   <= w_byp_dbz;
               if (w_bypass) r_result <= w_byp_res;
            end
            S_BUSY: begin
               r_hi  <= w_hi_nx;
               r_lo  <= w_lo_nx;
               r_cnt <= w_last ? '0 : r_cnt + CW'(1);
               if (w_last) r_result <= w_final;
            end
            default: ;
         endcase
      end
   end

   assign io.in_ready    = (r_state == S_IDLE);
   assign io.out_valid   = (r_state == S_DONE);
   assign io.result      = r_result;
   assign io.div_by_zero = r_dbz;
endmodule
